// File: rtl/toa_code_assembler_if.sv
// Hit input and assembled-word output bundle for toa_code_assembler.
// master = hit source / word consumer, slave = assembler.
interface toa_code_assembler_if;
    logic       hit_valid;
    logic [6:0] fine_code;
    logic [1:0] bubble_err;
    logic [2:0] coarse_cnt;
    logic       out_ready;
    logic       out_valid;
    logic [9:0] toa_code;
    logic [1:0] out_flags;
    logic [7:0] drop_cnt;
    logic [7:0] err_cnt;

    modport master (
        output hit_valid,
        output fine_code,
        output bubble_err,
        output coarse_cnt,
        output out_ready,
        input  out_valid,
        input  toa_code,
        input  out_flags,
        input  drop_cnt,
        input  err_cnt
    );

    modport slave (
        input  hit_valid,
        input  fine_code,
        input  bubble_err,
        input  coarse_cnt,
        input  out_ready,
        output out_valid,
        output toa_code,
        output out_flags,
        output drop_cnt,
        output err_cnt
    );
endinterface

// File: rtl/toa_code_assembler.sv
// Registers a fine/coarse hit, assembles coarse*126+fine into a 10-bit TOA code and
// buffers it in a small FIFO. Define TOA_ERR_COUNT_EN to enable the flagged-word counter.
module toa_code_assembler #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic                 clk,
    input logic                 reset,
    toa_code_assembler_if.slave bus
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    typedef struct packed {
        logic [1:0] flags;
        logic [9:0] code;
    } word_t;

    // Stage 1: input capture
    logic       s1_valid_q;
    logic [6:0] s1_fine_q;
    logic [1:0] s1_bubble_q;
    logic [2:0] s1_coarse_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_fine_q   <= '0;
            s1_bubble_q <= '0;
            s1_coarse_q <= '0;
        end else begin
            s1_valid_q <= bus.hit_valid;
            if (bus.hit_valid) begin
                s1_fine_q   <= bus.fine_code;
                s1_bubble_q <= bus.bubble_err;
                s1_coarse_q <= bus.coarse_cnt;
            end
        end
    end

    // Stage 2: assembly, written straight into the FIFO
    logic       fine_oor;
    logic [6:0] fine_clamped;
    logic [9:0] coarse_x126;
    word_t      asm_word;

    always_comb begin
        fine_oor       = (s1_fine_q >= 7'd126);
        fine_clamped   = fine_oor ? 7'd125 : s1_fine_q;
        // coarse*126 = coarse*128 - coarse*2
        coarse_x126    = {s1_coarse_q, 7'b0} - {6'b0, s1_coarse_q, 1'b0};
        asm_word.code  = coarse_x126 + {3'b0, fine_clamped};
        asm_word.flags = {fine_oor, |s1_bubble_q};
    end

    // Output FIFO
    word_t mem_q [FIFO_DEPTH];
    ptr_t  wr_ptr_q, wr_ptr_d;
    ptr_t  rd_ptr_q, rd_ptr_d;
    cnt_t  count_q, count_d;
    logic  full;
    logic  fifo_valid;
    logic  push_req;
    logic  push;
    logic  pop;
    logic  drop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        fifo_valid = (count_q != '0);
        full       = (count_q == CntW'(FIFO_DEPTH));
        push_req   = s1_valid_q;
        pop        = fifo_valid && bus.out_ready;
        // A full FIFO that is popping this cycle still has room
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= asm_word;
        end
    end

    // Drop counter
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

`ifdef TOA_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (push && (asm_word.flags != 2'b00) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

    // Outputs: gated so an empty or reset FIFO presents all-zero
    word_t head;

    always_comb begin
        head          = mem_q[rd_ptr_q];
        bus.out_valid = fifo_valid;
        bus.toa_code  = fifo_valid ? head.code  : '0;
        bus.out_flags = fifo_valid ? head.flags : '0;
        bus.drop_cnt  = drop_cnt_q;
    end

endmodule

// File: tb/tb_toa_code_assembler.sv
// Directed bench for toa_code_assembler: a scoreboard queue of expected words, popped
// whenever the DUT hands a word downstream.
module tb_toa_code_assembler;

    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [9:0] code;
        logic [1:0] flags;
    } word_t;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    word_t sb[$];

    toa_code_assembler_if bus ();

    toa_code_assembler #(
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic word_t model(input int fine, input int coarse, input int bubble);
        word_t w;
        int    f;
        f       = (fine > 125) ? 125 : fine;
        w.code  = 10'(coarse * 126 + f);
        w.flags = {(fine > 125) ? 1'b1 : 1'b0, (bubble != 0) ? 1'b1 : 1'b0};
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input int fine, input int coarse, input int bubble, input bit kept);
        bus.hit_valid  = 1'b1;
        bus.fine_code  = 7'(fine);
        bus.coarse_cnt = 3'(coarse);
        bus.bubble_err = 2'(bubble);
        if (kept) sb.push_back(model(fine, coarse, bubble));
        tick();
        bus.hit_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.hit_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        tick();
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_idle"}, bus.out_valid, 0);
    endtask

    // Word monitor: a transfer happens at the next posedge
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_assert++;
            assert (sb.size() != 0)
            else begin
                n_fail++;
                $error("FAIL unexpected_word: observed code %0d expected no word", bus.toa_code);
            end
            if (sb.size() != 0) begin
                word_t w;
                w = sb.pop_front();
                check("sb_code", bus.toa_code, w.code);
                check("sb_flags", bus.out_flags, w.flags);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.hit_valid  = 1'b0;
        bus.fine_code  = '0;
        bus.coarse_cnt = '0;
        bus.bubble_err = '0;
        bus.out_ready  = 1'b1;
        repeat (2) tick();

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_toa_code", bus.toa_code, 0);
        check("rst_out_flags", bus.out_flags, 0);
        check("rst_drop_cnt", bus.drop_cnt, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        rst = 1'b0;

        // Latency and basic assembly
        hit(37, 3, 0, 1);
        check("lat_n1_valid", bus.out_valid, 0);
        tick();
        check("lat_n2_valid", bus.out_valid, 1);
        check("lat_code", bus.toa_code, 415);
        check("lat_flags", bus.out_flags, 0);
        tick();

        // Out-of-range fine code clamps
        hit(127, 7, 0, 1);
        tick();
        check("oor_code", bus.toa_code, 1007);
        check("oor_flags", bus.out_flags, 2);
        tick();
`ifdef TOA_ERR_COUNT_EN
        check("oor_err_cnt", bus.err_cnt, 1);
`else
        check("oor_err_cnt", bus.err_cnt, 0);
`endif

        // Back-to-back patterns with a consumer always ready
        hit(0, 0, 1, 1);
        hit(125, 0, 0, 1);
        hit(126, 2, 0, 1);
        hit(5, 1, 2, 1);
        hit(100, 5, 3, 1);
        hit(64, 6, 0, 1);
        drain("b2b");
        check("b2b_drop_cnt", bus.drop_cnt, 0);

        // Overflow with stalled consumer
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) hit(10 * (i + 1), i + 1, 0, i < DEPTH);
        repeat (2) tick();
        check("ovf_drop_cnt", bus.drop_cnt, 3);
        check("ovf_valid", bus.out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            check("ovf_head_code", bus.toa_code, sb[0].code);
            check("ovf_head_flags", bus.out_flags, sb[0].flags);
            tick();
        end
        bus.out_ready = 1'b1;
        drain("ovf");
        check("ovf_drop_hold", bus.drop_cnt, 3);

        // Asynchronous reset with words buffered
        do_reset();
        bus.out_ready = 1'b0;
        hit(1, 1, 0, 1);
        hit(2, 2, 0, 1);
        hit(3, 3, 0, 0);
        repeat (2) tick();
        check("arst_pre_valid", bus.out_valid, 1);
        check("arst_pre_drop", bus.drop_cnt, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_code", bus.toa_code, 0);
        check("arst_drop", bus.drop_cnt, 0);
        sb.delete();
        tick();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        hit(64, 4, 0, 1);
        check("arst_n1_valid", bus.out_valid, 0);
        tick();
        check("arst_n2_valid", bus.out_valid, 1);
        check("arst_n2_code", bus.toa_code, 568);
        drain("arst");

        // Drop counter saturation
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 300; i++) hit(i % 126, i % 8, 0, i < DEPTH);
        repeat (2) tick();
        check("sat_drop_cnt", bus.drop_cnt, 255);
        bus.out_ready = 1'b1;
        drain("sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
